// File: rtl/ram_access_ctrl.sv
// Requester-side controller for the dual-port RAM: one load/store in flight,
// absorbs the RAM's one-cycle read latency and turns byte-masked stores into RMW.
module ram_access_ctrl #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_be_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            ram_wen_o,
  output logic [AW-1:0]   ram_waddr_o,
  output logic [DW-1:0]   ram_wdata_o,
  output logic            ram_ren_o,
  output logic [AW-1:0]   ram_raddr_o,
  input  logic [DW-1:0]   ram_rdata_i
);
  localparam int BW = DW / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]    state;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [BW-1:0] be_q;
  logic [DW-1:0] merged;

  // RAM has no byte enables: splice store bytes over the word just read.
  for (genvar i = 0; i < BW; i++) begin : g_merge
    assign merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata_i[8*i +: 8];
  end

  assign req_ready_o = (state == IDLE) & rst;
  assign rsp_valid_o = (state == RSP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_o <= '0;
      ram_wen_o   <= 1'b0;
      ram_waddr_o <= '0;
      ram_wdata_o <= '0;
      ram_ren_o   <= 1'b0;
      ram_raddr_o <= '0;
    end else begin
      ram_wen_o <= 1'b0;
      ram_ren_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          we_q    <= req_we_i;
          addr_q  <= req_addr_i;
          wdata_q <= req_wdata_i;
          be_q    <= req_be_i;
          if (req_we_i && req_be_i == '1) begin
            ram_wen_o   <= 1'b1;
            ram_waddr_o <= req_addr_i;
            ram_wdata_o <= req_wdata_i;
            rsp_rdata_o <= '0;
            state       <= RSP;
          end else if (req_we_i && req_be_i == '0) begin
            rsp_rdata_o <= '0;
            state       <= RSP;
          end else begin
            ram_ren_o   <= 1'b1;
            ram_raddr_o <= req_addr_i;
            state       <= RD;
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (we_q) begin
            ram_wen_o   <= 1'b1;
            ram_waddr_o <= addr_q;
            ram_wdata_o <= merged;
            rsp_rdata_o <= '0;
          end else begin
            rsp_rdata_o <= ram_rdata_i;
          end
          state <= RSP;
        end
        RSP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural registered-read RAM.
module tb_ram_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  ram_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .ram_ren_o(ram_ren), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", req_ready); end
    checks++; if ({rsp_valid, ram_wen, ram_ren} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b exp 000", {rsp_valid, ram_wen, ram_ren}); end
    checks++; if ({rsp_rdata, ram_wdata} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", {rsp_rdata, ram_wdata}); end
    checks++; if ({ram_waddr, ram_raddr} !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", {ram_waddr, ram_raddr}); end
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_full_store();
    drive(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fs_ready: got %b exp 1", req_ready); end
    tick(); req_valid = 1'b0;
    checks++; if ({ram_wen, ram_ren, rsp_valid} !== 3'b101) begin errors++; $display("FAIL fs_t1_strobes: got %b exp 101", {ram_wen, ram_ren, rsp_valid}); end
    checks++; if (ram_waddr !== 12'h010 || ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fs_t1_wr: got %h/%h exp 010/deadbeef", ram_waddr, ram_wdata); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL fs_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fs_t1_ready: got %b exp 0", req_ready); end
    tick();
    checks++; if ({ram_wen, rsp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL fs_t2: got %b exp 001", {ram_wen, rsp_valid, req_ready}); end
  endtask

  task automatic test_load(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b0, a, 32'hFFFF_FFFF, 4'h0);
    tick(); req_valid = 1'b0;
    checks++; if ({ram_ren, ram_wen, rsp_valid} !== 3'b100 || ram_raddr !== a) begin errors++; $display("FAIL ld_t1: got %b/%h exp 100/%h", {ram_ren, ram_wen, rsp_valid}, ram_raddr, a); end
    tick();
    checks++; if ({ram_ren, ram_wen, rsp_valid} !== 3'b000) begin errors++; $display("FAIL ld_t2: got %b exp 000", {ram_ren, ram_wen, rsp_valid}); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin errors++; $display("FAIL ld_t3: got %b/%h exp 1/%h", rsp_valid, rsp_rdata, exp); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ld_t4: got %b%b exp 01", rsp_valid, req_ready); end
  endtask

  task automatic test_partial(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be, input logic [DW-1:0] exp);
    drive(1'b1, a, d, be);
    tick(); req_valid = 1'b0;
    checks++; if ({ram_ren, ram_wen, rsp_valid} !== 3'b100 || ram_raddr !== a) begin errors++; $display("FAIL ps_t1: got %b/%h exp 100/%h", {ram_ren, ram_wen, rsp_valid}, ram_raddr, a); end
    tick();
    checks++; if ({ram_ren, ram_wen, rsp_valid} !== 3'b000) begin errors++; $display("FAIL ps_t2: got %b exp 000", {ram_ren, ram_wen, rsp_valid}); end
    tick();
    checks++; if ({ram_ren, ram_wen, rsp_valid} !== 3'b011) begin errors++; $display("FAIL ps_t3_strobes: got %b exp 011", {ram_ren, ram_wen, rsp_valid}); end
    checks++; if (ram_waddr !== a || ram_wdata !== exp) begin errors++; $display("FAIL ps_t3_wr: got %h/%h exp %h/%h", ram_waddr, ram_wdata, a, exp); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL ps_rdata: got %h exp 0", rsp_rdata); end
    tick();
    checks++; if ({ram_wen, rsp_valid} !== 2'b00 || mem[a] !== exp) begin errors++; $display("FAIL ps_t4: got %b/%h exp 00/%h", {ram_wen, rsp_valid}, mem[a], exp); end
  endtask

  task automatic test_empty_store();
    drive(1'b1, 12'h010, 32'hCAFEF00D, 4'h0);
    tick(); req_valid = 1'b0;
    checks++; if ({ram_wen, ram_ren, rsp_valid} !== 3'b001 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL es_t1: got %b/%h exp 001/0", {ram_wen, ram_ren, rsp_valid}, rsp_rdata); end
    tick();
    checks++; if (ram_wen !== 1'b0 || req_ready !== 1'b1 || mem[12'h010] !== 32'h1234BEAA) begin errors++; $display("FAIL es_t2: got %b%b/%h exp 01/1234beaa", ram_wen, req_ready, mem[12'h010]); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive(1'b0, 12'h010, 32'h0, 4'h0);
    tick(); req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234BEAA || req_ready !== 1'b0 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v%b d%h r%b w%b e%b exp v1 d1234beaa r0 w0 e0", i, rsp_valid, rsp_rdata, req_ready, ram_wen, ram_ren);
      end
      if (i < 4) tick();
    end
    // Handshake cycle: offer a new store, which must not be taken yet.
    rsp_ready = 1'b1;
    drive(1'b1, 12'h020, 32'h11111111, 4'hF);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_ready: got %b exp 0", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || ram_wen !== 1'b0) begin errors++; $display("FAIL bp_after: got %b%b%b exp 010", rsp_valid, req_ready, ram_wen); end
    tick(); req_valid = 1'b0;
    checks++; if (ram_wen !== 1'b1 || ram_waddr !== 12'h020 || ram_wdata !== 32'h11111111) begin errors++; $display("FAIL bp_store: got %b/%h/%h exp 1/020/11111111", ram_wen, ram_waddr, ram_wdata); end
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    drive(1'b1, 12'h020, 32'h000000AA, 4'h1);
    tick(); req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({ram_wen, rsp_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL rmw_rst: got %b exp 000", {ram_wen, rsp_valid, req_ready}); end
    rst = 1'b1;
    tick();
    checks++; if ({ram_wen, rsp_valid, req_ready} !== 3'b001 || mem[12'h020] !== 32'h11111111) begin errors++; $display("FAIL rmw_after: got %b/%h exp 001/11111111", {ram_wen, rsp_valid, req_ready}, mem[12'h020]); end
    test_load(12'h020, 32'h11111111);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_rdata = '0;
    test_reset();
    test_full_store();
    test_load(12'h010, 32'hDEADBEEF);
    test_partial(12'h010, 32'h000000AA, 4'h1, 32'hDEADBEAA);
    test_partial(12'h010, 32'h12340000, 4'hC, 32'h1234BEAA);
    test_empty_store();
    test_backpressure();
    test_reset_mid_rmw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
